// File: rtl/register_writeback_pkg.sv
// Shared widths and constants for the register bank write path.
package register_writeback_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    // Hard-wired zero register: writes to it are dropped.
    localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/register_writeback_wb_fifo.sv
// In-order writeback queue: storage, pointers, occupancy count and per-slot valid bits.
module register_writeback_wb_fifo
    import register_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] slot_addr [DEPTH],
    output logic [DATA_W-1:0] slot_data [DEPTH],
    output logic [DEPTH-1:0]  slot_valid,
    output logic [PTR_W-1:0]  head_ptr,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q;

    // Payload needs no reset; valid bits guard every consumer.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_addr[tail_q] <= push_addr;
            slot_data[tail_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign slot_valid = valid_q;
    assign head_ptr   = head_q;
    assign head_addr  = slot_addr[head_q];
    assign head_data  = slot_data[head_q];
    assign count      = count_q;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/register_writeback.sv
// Register bank write side: buffered in-order commit with a youngest-match bypass lookup.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] byp_addr,
    output logic              byp_hit,
    output logic [DATA_W-1:0] byp_data,
    output logic [ADDR_W-1:0] pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              push;
    logic [ADDR_W-1:0] slot_addr [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0]  slot_valid;
    logic [PTR_W-1:0]  head_ptr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [PTR_W-1:0]  byp_idx;

    // Held low while reset is asserted; otherwise depends on stored occupancy only.
    assign in_ready = reset_n && !full;
    // Register-zero results complete the handshake but are never queued.
    assign push     = in_valid && in_ready && (in_addr != ADDR_W'(REG_ZERO));
    assign wr_en    = !empty && !wr_stall;
    assign wr_addr  = empty ? '0 : head_addr;
    assign wr_data  = empty ? '0 : head_data;
    assign pending  = ADDR_W'(count);

    register_writeback_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_addr  (in_addr),
        .push_data  (in_data),
        .pop        (wr_en),
        .slot_addr  (slot_addr),
        .slot_data  (slot_data),
        .slot_valid (slot_valid),
        .head_ptr   (head_ptr),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Scan oldest to youngest so the last match, nearest the tail, wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = head_ptr + PTR_W'(i);
            if (slot_valid[byp_idx] && (slot_addr[byp_idx] == byp_addr) &&
                (byp_addr != ADDR_W'(REG_ZERO))) begin
                byp_hit  = 1'b1;
                byp_data = slot_data[byp_idx];
            end
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with a commit-order scoreboard.
module tb_register_writeback;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  byp_addr;
    logic        byp_hit;
    logic [31:0] byp_data;
    logic [4:0]  pending;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t sb [$];
    int vectors;
    int errors;

    register_writeback dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .byp_addr (byp_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic s);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wr_stall = s;
        #1;
    endtask

    // Observe the pre-edge handshake, update the scoreboard, then advance one clock.
    task automatic tick();
        wb_entry_t e;
        if (wr_en) begin
            if (sb.size() == 0) begin
                chk("commit_unexpected", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("commit_addr", 32'(wr_addr), 32'(e.addr));
                chk("commit_data", wr_data, e.data);
            end
        end
        if (in_valid && in_ready && in_addr != 5'd0) begin
            sb.push_back({in_addr, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        wr_stall = 1'b0;
        byp_addr = '0;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_byp_hit", 32'(byp_hit), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single write latency
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        chk("lat_ready", 32'(in_ready), 32'd1);
        chk("lat_wr_en_k", 32'(wr_en), 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        chk("lat_wr_en", 32'(wr_en), 32'd1);
        chk("lat_wr_addr", 32'(wr_addr), 32'd5);
        chk("lat_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("lat_pending1", 32'(pending), 32'd1);
        tick();
        chk("lat_pending0", 32'(pending), 32'd0);
        chk("lat_idle_addr", 32'(wr_addr), 32'd0);

        // Fill while stalled
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b1);
            chk("fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b1, 5'd5, 32'hA5, 1'b1);
        chk("full_pending", 32'(pending), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_stalled_wr_en", 32'(wr_en), 32'd0);
        tick();
        drive(1'b1, 5'd6, 32'hA6, 1'b0);
        chk("full_no_fifth", 32'(pending), 32'd4);
        chk("full_pop_ready", 32'(in_ready), 32'd0);
        chk("drain_wr_en", 32'(wr_en), 32'd1);
        chk("drain_first", 32'(wr_addr), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            chk("drain_wr_en", 32'(wr_en), 32'd1);
            chk("drain_order", 32'(wr_addr), 32'(i));
            tick();
        end
        chk("drain_pending", 32'(pending), 32'd0);

        // Register-zero filter
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0);
        chk("r0_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 5'd7, 32'h7, 1'b0);
        chk("r0_pending", 32'(pending), 32'd0);
        chk("r0_no_write", 32'(wr_en), 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        byp_addr = 5'd0;
        #1;
        chk("r7_pending", 32'(pending), 32'd1);
        chk("r7_wr_en", 32'(wr_en), 32'd1);
        chk("r7_addr", 32'(wr_addr), 32'd7);
        chk("r0_byp_hit", 32'(byp_hit), 32'd0);
        tick();
        chk("r7_done", 32'(pending), 32'd0);

        // Bypass youngest match
        drive(1'b1, 5'd9, 32'h1, 1'b1);
        tick();
        drive(1'b1, 5'd9, 32'h2, 1'b1);
        tick();
        byp_addr = 5'd12;
        drive(1'b1, 5'd12, 32'h33, 1'b1);
        chk("byp_same_cycle", 32'(byp_hit), 32'd0);
        chk("byp_same_cycle_d", byp_data, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        chk("byp_r12_hit", 32'(byp_hit), 32'd1);
        chk("byp_r12_data", byp_data, 32'h33);
        byp_addr = 5'd9;
        #1;
        chk("byp_r9_hit", 32'(byp_hit), 32'd1);
        chk("byp_r9_young", byp_data, 32'h2);
        byp_addr = 5'd10;
        #1;
        chk("byp_miss", 32'(byp_hit), 32'd0);
        chk("byp_miss_d", byp_data, 32'd0);
        byp_addr = 5'd9;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        chk("byp_pop0_data", byp_data, 32'h2);
        tick();
        chk("byp_head_wr_en", 32'(wr_en), 32'd1);
        chk("byp_pop1_hit", 32'(byp_hit), 32'd1);
        chk("byp_pop1_data", byp_data, 32'h2);
        tick();
        chk("byp_pop2_hit", 32'(byp_hit), 32'd0);
        chk("byp_pop2_data", byp_data, 32'd0);
        tick();
        chk("byp_pending", 32'(pending), 32'd0);

        // Steady-state concurrent accept and pop
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h101, 1'b0);
            chk("ss_ready", 32'(in_ready), 32'd1);
            if (i > 1) begin
                chk("ss_pending", 32'(pending), 32'd1);
                chk("ss_wr_en", 32'(wr_en), 32'd1);
                chk("ss_wr_addr", 32'(wr_addr), 32'(i - 1));
            end
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("ss_pending0", 32'(pending), 32'd0);

        // Reset mid-operation discards queued writes
        drive(1'b1, 5'd3, 32'h11, 1'b1);
        tick();
        drive(1'b1, 5'd4, 32'h22, 1'b1);
        tick();
        byp_addr = 5'd3;
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        chk("mid_pending", 32'(pending), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_byp", 32'(byp_hit), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_commit", 32'(wr_en), 32'd0);
            tick();
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
